// File: rtl/sum_window_pkg.sv
// Shared types and default sizing for the sum window accumulator.
package sum_window_pkg;

    // Two-state window controller: collecting samples, or holding a finished window.
    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    localparam int DEF_IN_W   = 8;
    localparam int DEF_ACC_W  = 16;
    localparam int DEF_WINDOW = 4;

endpackage

// File: rtl/sum_window_accumulator.sv
// Sum window accumulator: totals a stream of adder sums over WINDOW samples
// (or fewer when flushed) and presents total, sample count and overflow on a
// held output handshake.
// Optional feature macro: ACC_SATURATE_EN (clamp the accumulator on overflow
// instead of wrapping).
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high. The producer holds data stable while valid is high and not yet accepted;
// the consumer may drive ready freely. out_* stay unchanged while out_valid is high
// and out_ready is low. in_ready is a pure function of the state register, so no
// combinational path exists from out_ready to in_ready.
module sum_window_accumulator
    import sum_window_pkg::*;
#(
    parameter int IN_W   = DEF_IN_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int WINDOW = DEF_WINDOW,
    localparam int CNT_W = $clog2(WINDOW + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [ACC_W-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             state_dbg
);

    state_t             state, state_n;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic               ovf_r;

    logic               accept;
    logic [ACC_W:0]     acc_sum;
    logic               carry;
    logic [ACC_W-1:0]   acc_add;
    logic [ACC_W-1:0]   acc_upd;
    logic [CNT_W-1:0]   cnt_upd;
    logic               ovf_upd;
    logic               emit;

    assign in_ready  = (state == ST_ACCUM);
    assign state_dbg = state;

    // Datapath and next-state: add the accepted sample, decide when the window closes.
    always_comb begin
        accept  = 1'b0;
        acc_sum = '0;
        carry   = 1'b0;
        acc_add = acc;
        acc_upd = acc;
        cnt_upd = cnt;
        ovf_upd = ovf_r;
        emit    = 1'b0;
        state_n = state;

        accept  = in_valid && (state == ST_ACCUM);
        acc_sum = {1'b0, acc} + (ACC_W + 1)'(in_data);
        carry   = acc_sum[ACC_W];
`ifdef ACC_SATURATE_EN
        // Once the window has overflowed the total stays pinned at full scale.
        acc_add = (carry || ovf_r) ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
`else
        acc_add = acc_sum[ACC_W-1:0];
`endif
        if (accept) begin
            acc_upd = acc_add;
            cnt_upd = cnt + CNT_W'(1);
            ovf_upd = ovf_r | carry;
        end

        case (state)
            ST_ACCUM: begin
                // A flush on an empty window with no sample arriving is dropped.
                emit = (accept && (cnt == CNT_W'(WINDOW - 1))) ||
                       (flush && ((cnt != '0) || accept));
                if (emit) state_n = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) state_n = ST_ACCUM;
            end
            default: state_n = ST_ACCUM;
        endcase
    end

    // State, accumulator and output registers; reset discards any partial or held window.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_ACCUM;
            acc       <= '0;
            cnt       <= '0;
            ovf_r     <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state <= state_n;
            if (emit) begin
                out_data  <= acc_upd;
                out_count <= cnt_upd;
                out_ovf   <= ovf_upd;
                out_valid <= 1'b1;
                acc       <= '0;
                cnt       <= '0;
                ovf_r     <= 1'b0;
            end else begin
                acc   <= acc_upd;
                cnt   <= cnt_upd;
                ovf_r <= ovf_upd;
                if ((state == ST_HOLD) && out_ready) out_valid <= 1'b0;
            end
        end
    end

endmodule
